apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameters: ADDR_W, 16, APB address width; DATA_W, 32, APB data width (multiple of 8); TIMEOUT, 255, maximum ACCESS cycles before abort (0 = no timeout).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  in  1  command request; cmd_ready  out  1  command accepted when both high.
REQ-005 cmd_write  in  1  1 = write, 0 = read; cmd_addr  in  ADDR_W; cmd_wdata  in  DATA_W; cmd_wstrb  in  DATA_W/8.
REQ-006 rsp_valid  out  1  one-cycle response pulse; rsp_rdata  out  DATA_W; rsp_err  out  1  PSLVERR or timeout; rsp_timeout  out  1  abort by timeout.
REQ-007 APB side: psel, penable, pwrite  out  1; paddr  out  ADDR_W; pwdata  out  DATA_W; pstrb  out  DATA_W/8; prdata  in  DATA_W; pready, pslverr  in  1.

Function
REQ-008 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-009 cmd_ready SHALL be 1 only in IDLE and not in reset; no command is buffered.
REQ-010 IDLE -> SETUP on cmd_valid & cmd_ready; cmd_write/addr/wdata/wstrb are captured on that edge.
REQ-011 SETUP: psel=1, penable=0; always lasts exactly one cycle, then ACCESS.
REQ-012 ACCESS: psel=1, penable=1; held until pready=1 or timeout.
REQ-013 paddr, pwrite, pwdata, pstrb SHALL stay stable from SETUP through the last ACCESS cycle; pstrb = 0 for reads.
REQ-014 On ACCESS & pready: rsp_rdata = prdata for reads and 0 for writes; rsp_err = pslverr; rsp_timeout = 0; next state RESP.
REQ-015 Timeout counter: cleared on SETUP; increments each ACCESS cycle with pready=0; if TIMEOUT != 0 and count reaches TIMEOUT, abort to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-016 pready=1 in the same cycle the count reaches TIMEOUT SHALL complete normally (pready wins).
REQ-017 RESP: rsp_valid=1 for exactly one cycle, psel=penable=0; next state IDLE; no backpressure on response.
REQ-018 rsp_rdata/rsp_err/rsp_timeout SHALL hold their values until the next RESP; only rsp_valid is the qualifier.
REQ-019 Latency: accept at edge N -> SETUP cycle N+1, first ACCESS N+2; pready in cycle N+1+k (k>=1) -> rsp_valid in cycle N+2+k; next cmd_ready the cycle after RESP.
REQ-020 Outside SETUP/ACCESS psel=penable=0; paddr/pwdata/pstrb/pwrite retain last driven values.
REQ-021 pready/pslverr/prdata SHALL be ignored outside ACCESS.
REQ-022 Timeout counter width SHALL be clog2(TIMEOUT+1), min 1 bit; it SHALL not wrap.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, counter 0, and all outputs 0 (cmd_ready=0 while rst=0).
REQ-024 Reset mid-transfer SHALL drop psel/penable asynchronously and discard the transfer with no rsp_valid.
REQ-025 cmd_ready SHALL rise on the first clock edge after rst deasserts.

Verification
REQ-026 Write 0x50 data 0x1 strb 0xF, pready=1 immediately -> one SETUP, one ACCESS cycle, pwrite=1, pstrb=0xF, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-027 Read 0x50, slave prdata=0x3 with 2 wait states -> penable high 3 cycles, paddr stable, pstrb=0, rsp_rdata=0x3, rsp_valid single pulse.
REQ-028 Read with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0.
REQ-029 TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1, rsp_rdata=0; pready=1 on 4th cycle instead -> normal completion.
REQ-030 Back-to-back commands with cmd_valid held high -> accepts spaced per REQ-019, psel low for >=1 cycle between transfers.
REQ-031 rst=0 during ACCESS -> psel/penable 0 without waiting for clk, no rsp_valid, cmd_ready returns 1 one edge after release.

Source files
------------

// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - single-command APB initiator with per-access timeout
module apb_initiator #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;
  // Counter only has to reach TIMEOUT; keep one bit when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Value the counter holds in the ACCESS cycle that, if still not ready, aborts.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;

  logic                w_cnt_sat;
  logic                w_timeout_hit;

  assign w_cnt_sat     = &r_cnt;
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;

  // Transfer sequencer: all outputs are registered and cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            r_pstrb     <= cmd_write ? cmd_wstrb : '0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_state     <= S_SETUP;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_cnt     <= '0;
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            // A ready slave wins even in the cycle the count would expire.
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_err     <= pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= S_RESP;
          end else begin
            if (!w_cnt_sat) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout_hit) begin
              r_rsp_rdata   <= '0;
              r_rsp_err     <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_rsp_valid   <= 1'b1;
              r_psel        <= 1'b0;
              r_penable     <= 1'b0;
              r_state       <= S_RESP;
            end
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// tb/tb_apb_initiator.sv - randomized self-checking bench for apb_initiator
module tb_apb_initiator;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_initiator #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  // Expected outputs for the current cycle
  logic        e_ready, e_psel, e_pen, e_rv, e_pwrite, e_err, e_to;
  logic [15:0] e_paddr;
  logic [31:0] e_pwdata, e_rdata;
  logic [3:0]  e_pstrb;

  int n_chk = 0;
  int n_err = 0;
  int n_txn = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Observed timing, used to pin the model with literal expectations
  int acc_cyc = 0;
  int pen_cnt = 0;
  int last_pen = 0;
  int last_lat = 0;
  int rsp_pulses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index, used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then timing observation
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready",   32'(cmd_ready),   32'(e_ready));
      chk("psel",        32'(psel),        32'(e_psel));
      chk("penable",     32'(penable),     32'(e_pen));
      chk("rsp_valid",   32'(rsp_valid),   32'(e_rv));
      chk("pwrite",      32'(pwrite),      32'(e_pwrite));
      chk("paddr",       32'(paddr),       32'(e_paddr));
      chk("pwdata",      pwdata,           e_pwdata);
      chk("pstrb",       32'(pstrb),       32'(e_pstrb));
      chk("rsp_rdata",   rsp_rdata,        e_rdata);
      chk("rsp_err",     32'(rsp_err),     32'(e_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        pen_cnt = 0;
      end
      if (penable) pen_cnt++;
      if (rsp_valid) begin
        rsp_pulses++;
        last_lat = cyc - acc_cyc;
        last_pen = pen_cnt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_exp();
    e_ready = 0; e_psel = 0; e_pen = 0; e_rv = 0; e_pwrite = 0; e_err = 0; e_to = 0;
    e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_pstrb = '0;
  endtask

  task automatic rand_slave();
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
  endtask

  // One full transfer, starting in an IDLE cycle with cmd_ready expected high.
  // w = wait states before pready; the transfer times out if w+1 exceeds TO.
  task automatic run_txn(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int w, input logic er,
                         input logic [31:0] rd);
    logic to;
    int   len;
    to  = (TO != 0) && (w + 1 > TO);
    len = to ? TO : w + 1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = st;
    rand_slave();
    e_ready = 1; e_psel = 0; e_pen = 0; e_rv = 0;
    step();
    junk_cmd(); rand_slave();
    e_ready = 0; e_psel = 1; e_pen = 0;
    e_paddr = a; e_pwrite = wr; e_pwdata = wd; e_pstrb = wr ? st : 4'h0;
    for (int j = 1; j <= len; j++) begin
      step();
      junk_cmd();
      e_pen = 1;
      if (j == w + 1) begin
        pready = 1; pslverr = er; prdata = rd;
      end else begin
        pready = 0; pslverr = 1'($urandom); prdata = $urandom;
      end
    end
    step();
    junk_cmd(); rand_slave();
    e_psel = 0; e_pen = 0; e_rv = 1;
    e_rdata = (to || wr) ? 32'h0 : rd;
    e_err   = to ? 1'b1 : er;
    e_to    = to;
    n_txn++;
    step();
    cmd_valid = 0; rand_slave();
    e_rv = 0; e_ready = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      cmd_valid = 0;
      rand_slave();
    end
  endtask

  task automatic reset_mid();
    int pulses_before;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h1234; cmd_wdata = 32'hCAFE0001; cmd_wstrb = 4'hF;
    rand_slave();
    e_ready = 1; e_psel = 0; e_pen = 0; e_rv = 0;
    step();
    junk_cmd(); rand_slave();
    e_ready = 0; e_psel = 1; e_pen = 0;
    e_paddr = 16'h1234; e_pwrite = 0; e_pwdata = 32'hCAFE0001; e_pstrb = 4'h0;
    step();
    junk_cmd(); pready = 0; e_pen = 1;
    #2;
    rst = 0;
    zero_exp();
    pulses_before = rsp_pulses;
    #1;
    chk("async_psel",      32'(psel),      32'h0);
    chk("async_penable",   32'(penable),   32'h0);
    chk("async_cmd_ready", 32'(cmd_ready), 32'h0);
    repeat (2) begin
      step();
      junk_cmd(); rand_slave();
    end
    rst = 1;
    cmd_valid = 0;
    step();
    e_ready = 1;
    chk("no_rsp_on_reset", 32'(rsp_pulses), 32'(pulses_before));
  endtask

  initial begin
    rst = 1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    pready = 0; pslverr = 0; prdata = '0;
    zero_exp();
    #1;
    rst = 0;
    chk_en = 1;
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("reset_psel",      32'(psel),      32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) begin
      step();
      rand_slave();
    end
    rst = 1;
    step();
    e_ready = 1;

    // Directed write, slave ready immediately
    run_txn(1'b1, 16'h0050, 32'h1, 4'hF, 0, 1'b0, 32'hDEAD);
    chk("wr_latency",  32'(last_lat), 32'd3);
    chk("wr_pen_cyc",  32'(last_pen), 32'd1);
    chk("wr_rdata",    rsp_rdata,     32'h0);
    chk("wr_pstrb",    32'(pstrb),    32'hF);
    idle(1);

    // Directed read with two wait states
    run_txn(1'b0, 16'h0050, 32'h0, 4'hF, 2, 1'b0, 32'h3);
    chk("rd_pen_cyc",  32'(last_pen), 32'd3);
    chk("rd_latency",  32'(last_lat), 32'd5);
    chk("rd_rdata",    rsp_rdata,     32'h3);
    chk("rd_pstrb",    32'(pstrb),    32'h0);

    // Read with slave error
    run_txn(1'b0, 16'h0060, 32'h0, 4'h0, 1, 1'b1, 32'h77);
    chk("err_err",     32'(rsp_err),     32'h1);
    chk("err_timeout", 32'(rsp_timeout), 32'h0);

    // Timeout abort after TO access cycles
    run_txn(1'b0, 16'h0070, 32'h0, 4'h0, 20, 1'b0, 32'h55);
    chk("to_pen_cyc",  32'(last_pen),    32'd4);
    chk("to_latency",  32'(last_lat),    32'd6);
    chk("to_timeout",  32'(rsp_timeout), 32'h1);
    chk("to_err",      32'(rsp_err),     32'h1);
    chk("to_rdata",    rsp_rdata,        32'h0);

    // Ready on the last allowed access cycle completes normally
    run_txn(1'b0, 16'h0074, 32'h0, 4'h0, 3, 1'b0, 32'h1234ABCD);
    chk("edge_pen_cyc", 32'(last_pen),    32'd4);
    chk("edge_timeout", 32'(rsp_timeout), 32'h0);
    chk("edge_rdata",   rsp_rdata,        32'h1234ABCD);

    // Back-to-back commands with cmd_valid held
    for (int i = 0; i < 3; i++) begin
      run_txn(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 2), 1'($urandom), $urandom);
    end

    // Randomized traffic with random gaps
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 6), 1'($urandom), $urandom);
      idle($urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of an access
    reset_mid();
    run_txn(1'b1, 16'h00A0, 32'hA5A5A5A5, 4'h3, 1, 1'b0, 32'h0);
    idle(2);

    chk("rsp_pulse_total", 32'(rsp_pulses), 32'(n_txn));
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
